// File: rtl/roce_qp_state_table_pkg.sv
// Shared encodings for the RoCE QP state table: entry states, event types,
// the BTH opcodes and AETH syndrome classes the table reacts to, and the
// per-entry record layout.
package roce_qp_state_table_pkg;

  typedef enum logic [1:0] {
    QP_DISABLED = 2'd0,
    QP_ACTIVE   = 2'd1,
    QP_ERROR    = 2'd2
  } qp_state_e;

  typedef enum logic [1:0] {
    EVT_ACKED      = 2'd0,
    EVT_NAK        = 2'd1,
    EVT_TX_PSN_ERR = 2'd2
  } qp_evt_e;

  localparam logic [7:0] OP_RDMA_WRITE_LAST      = 8'h08;
  localparam logic [7:0] OP_RDMA_WRITE_LAST_IMM  = 8'h09;
  localparam logic [7:0] OP_RDMA_WRITE_ONLY      = 8'h0A;
  localparam logic [7:0] OP_RDMA_WRITE_ONLY_IMM  = 8'h0B;
  localparam logic [7:0] OP_ACKNOWLEDGE          = 8'h11;

  // AETH syndrome[6:5] classes
  localparam logic [1:0] SYN_ACK  = 2'b00;
  localparam logic [1:0] SYN_RNR  = 2'b01;
  localparam logic [1:0] SYN_RSVD = 2'b10;
  localparam logic [1:0] SYN_NAK  = 2'b11;

  typedef struct packed {
    qp_state_e   state;
    logic [23:0] loc_qpn;
    logic [23:0] rem_qpn;
    logic [23:0] next_psn;
    logic [23:0] unacked_psn;
    logic [63:0] rem_addr;
    logic [31:0] r_key;
    logic [31:0] rem_ip_addr;
    logic [31:0] dma_len;
  } qp_entry_t;

  // Opcodes that close a write message and advance the remote address.
  function automatic logic is_write_end(input logic [7:0] op);
    return (op == OP_RDMA_WRITE_LAST)     || (op == OP_RDMA_WRITE_LAST_IMM) ||
           (op == OP_RDMA_WRITE_ONLY)     || (op == OP_RDMA_WRITE_ONLY_IMM);
  endfunction

endpackage

// File: rtl/roce_qp_state_table_lookup.sv
// Parallel QPN match across all table entries.
// Ports: key (QPN to find), qpn_flat (entry QPNs, entry i at [24*i +: 24]),
// en (per-entry match enable), hit / idx (lowest matching entry).
module roce_qp_lookup
  import roce_qp_state_table_pkg::*;
#(
  parameter int unsigned NUM_QP = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [23:0]          key,
  input  logic [NUM_QP*24-1:0] qpn_flat,
  input  logic [NUM_QP-1:0]    en,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      if (!hit && en[i] && (qpn_flat[i*24 +: 24] == key)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/roce_qp_state_table.sv
// Per-QP RoCE state table: tracks state, PSN window and remote address for
// NUM_QP queue pairs, updated by configuration, transmitted BTHs and
// received ACK/NAKs.
// Ports: clk/rst_n; cfg_* entry init/disable; s_tx_* TX BTH(+RETH) stream;
// s_rx_* RX BTH+AETH stream; rd_idx/rd_* registered entry read;
// stall per-entry transmit gate; m_tx_done_* write-complete pulse;
// m_rx_evt_* ACKED/NAK/TX_PSN_ERR event pulse.
module roce_qp_state_table
  import roce_qp_state_table_pkg::*;
#(
  parameter int unsigned NUM_QP          = 4,
  parameter int unsigned QP_IDX_W        = $clog2(NUM_QP),
  parameter int unsigned REM_ADDR_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic                cfg_disable,
  input  logic [QP_IDX_W-1:0] cfg_idx,
  input  logic [23:0]         cfg_loc_qpn,
  input  logic [23:0]         cfg_rem_qpn,
  input  logic [23:0]         cfg_loc_psn,
  input  logic [63:0]         cfg_rem_addr,
  input  logic [31:0]         cfg_r_key,
  input  logic [31:0]         cfg_rem_ip_addr,
  input  logic [31:0]         cfg_dma_len,
  input  logic                s_tx_valid,
  output logic                s_tx_ready,
  input  logic [7:0]          s_tx_op_code,
  input  logic [23:0]         s_tx_psn,
  input  logic [23:0]         s_tx_dest_qp,
  input  logic                s_tx_reth_valid,
  input  logic [63:0]         s_tx_reth_v_addr,
  input  logic [31:0]         s_tx_reth_length,
  input  logic                s_rx_valid,
  output logic                s_rx_ready,
  input  logic [7:0]          s_rx_op_code,
  input  logic [23:0]         s_rx_psn,
  input  logic [23:0]         s_rx_dest_qp,
  input  logic [7:0]          s_rx_aeth_syndrome,
  input  logic [QP_IDX_W-1:0] rd_idx,
  output logic [1:0]          rd_state,
  output logic [23:0]         rd_next_psn,
  output logic [23:0]         rd_unacked_psn,
  output logic [23:0]         rd_rem_qpn,
  output logic [63:0]         rd_rem_addr,
  output logic [31:0]         rd_r_key,
  output logic [31:0]         rd_rem_ip_addr,
  output logic [NUM_QP-1:0]   stall,
  output logic                m_tx_done_valid,
  output logic [QP_IDX_W-1:0] m_tx_done_idx,
  output logic                m_rx_evt_valid,
  output logic [QP_IDX_W-1:0] m_rx_evt_idx,
  output logic [1:0]          m_rx_evt_type
);

  qp_entry_t ent_q [NUM_QP];
  qp_entry_t ent_d [NUM_QP];

  // Reset asserts asynchronously; "run" rises two clocks after release so
  // no handshake or cfg is taken until the release is synchronised.
  logic [1:0] run_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_sync_q <= '0;
    else        run_sync_q <= {run_sync_q[0], 1'b1};
  end

  assign run        = run_sync_q[1];
  assign s_tx_ready = run && !cfg_valid;
  assign s_rx_ready = run && !cfg_valid;

  logic cfg_go, tx_acc, rx_acc;
  assign cfg_go = cfg_valid && run;
  assign tx_acc = s_tx_valid && s_tx_ready;
  assign rx_acc = s_rx_valid && s_rx_ready;

  // Only the ACK/NAK class bits of the syndrome and the RETH address are used.
  logic unused_in_bits;
  assign unused_in_bits = ^{s_rx_aeth_syndrome[7], s_rx_aeth_syndrome[4:0], s_tx_reth_length};

  logic [NUM_QP*24-1:0] tx_key_flat, rx_key_flat;
  logic [NUM_QP-1:0]    lookup_en;

  always_comb begin
    tx_key_flat = '0;
    rx_key_flat = '0;
    lookup_en   = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      tx_key_flat[i*24 +: 24] = ent_q[i].rem_qpn;
      rx_key_flat[i*24 +: 24] = ent_q[i].loc_qpn;
      lookup_en[i]            = (ent_q[i].state != QP_DISABLED);
    end
  end

  logic                tx_hit, rx_hit;
  logic [QP_IDX_W-1:0] tx_idx, rx_idx;

  roce_qp_lookup #(.NUM_QP(NUM_QP), .IDX_W(QP_IDX_W)) u_tx_lookup (
    .key      (s_tx_dest_qp),
    .qpn_flat (tx_key_flat),
    .en       (lookup_en),
    .hit      (tx_hit),
    .idx      (tx_idx)
  );

  roce_qp_lookup #(.NUM_QP(NUM_QP), .IDX_W(QP_IDX_W)) u_rx_lookup (
    .key      (s_rx_dest_qp),
    .qpn_flat (rx_key_flat),
    .en       (lookup_en),
    .hit      (rx_hit),
    .idx      (rx_idx)
  );

  logic [63:0] tx_addr;
  logic [23:0] ack_off, ack_win;
  logic        tx_done_d, tx_err_d, rx_evt_d;
  qp_evt_e     rx_type_d;

  // TX, then RX, then cfg are layered onto the same next-state copy: RX only
  // ever writes ERROR into state so ERROR dominates, and cfg overrides both.
  always_comb begin
    for (int unsigned i = 0; i < NUM_QP; i++) ent_d[i] = ent_q[i];
    tx_addr   = '0;
    ack_off   = '0;
    ack_win   = '0;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    rx_evt_d  = 1'b0;
    rx_type_d = EVT_ACKED;

    if (tx_acc && tx_hit && (ent_q[tx_idx].state == QP_ACTIVE)) begin
      if (s_tx_psn == ent_q[tx_idx].next_psn) begin
        ent_d[tx_idx].next_psn = s_tx_psn + 24'd1;
        tx_addr = s_tx_reth_valid ? s_tx_reth_v_addr : ent_q[tx_idx].rem_addr;
        if (is_write_end(s_tx_op_code)) begin
          tx_addr[REM_ADDR_WIDTH-1:0] = tx_addr[REM_ADDR_WIDTH-1:0] +
                                        REM_ADDR_WIDTH'(ent_q[tx_idx].dma_len);
          tx_done_d = 1'b1;
        end
        ent_d[tx_idx].rem_addr = tx_addr;
      end else begin
        ent_d[tx_idx].state = QP_ERROR;
        tx_err_d = 1'b1;
      end
    end

    if (rx_acc && rx_hit && (s_rx_op_code == OP_ACKNOWLEDGE)) begin
      // In-window test done as offsets from unacked_psn so it survives wrap.
      ack_off = s_rx_psn - ent_q[rx_idx].unacked_psn;
      ack_win = ent_q[rx_idx].next_psn - ent_q[rx_idx].unacked_psn;
      case (s_rx_aeth_syndrome[6:5])
        SYN_ACK: begin
          if (ack_off < ack_win) begin
            ent_d[rx_idx].unacked_psn = s_rx_psn + 24'd1;
            rx_evt_d  = 1'b1;
            rx_type_d = EVT_ACKED;
          end
        end
        SYN_RNR, SYN_NAK: begin
          ent_d[rx_idx].state = QP_ERROR;
          rx_evt_d  = 1'b1;
          rx_type_d = EVT_NAK;
        end
        default: ;
      endcase
    end

    if (cfg_go) begin
      if (cfg_disable) begin
        ent_d[cfg_idx].state = QP_DISABLED;
      end else begin
        ent_d[cfg_idx].state       = QP_ACTIVE;
        ent_d[cfg_idx].loc_qpn     = cfg_loc_qpn;
        ent_d[cfg_idx].rem_qpn     = cfg_rem_qpn;
        ent_d[cfg_idx].next_psn    = cfg_loc_psn;
        ent_d[cfg_idx].unacked_psn = cfg_loc_psn;
        ent_d[cfg_idx].rem_addr    = cfg_rem_addr;
        ent_d[cfg_idx].r_key       = cfg_r_key;
        ent_d[cfg_idx].rem_ip_addr = cfg_rem_ip_addr;
        ent_d[cfg_idx].dma_len     = cfg_dma_len;
      end
    end
  end

  always_comb begin
    stall = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      stall[i] = (ent_q[i].state != QP_ACTIVE) ||
                 ((ent_q[i].next_psn - ent_q[i].unacked_psn) >= 24'(MAX_OUTSTANDING));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_QP; i++) ent_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_QP; i++) ent_q[i] <= ent_d[i];
    end
  end

  // A same-cycle RX event wins the shared event port over TX_PSN_ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx_done_valid <= 1'b0;
      m_tx_done_idx   <= '0;
      m_rx_evt_valid  <= 1'b0;
      m_rx_evt_idx    <= '0;
      m_rx_evt_type   <= '0;
    end else begin
      m_tx_done_valid <= tx_done_d;
      m_tx_done_idx   <= tx_done_d ? tx_idx : '0;
      m_rx_evt_valid  <= rx_evt_d || tx_err_d;
      if (rx_evt_d) begin
        m_rx_evt_idx  <= rx_idx;
        m_rx_evt_type <= rx_type_d;
      end else if (tx_err_d) begin
        m_rx_evt_idx  <= tx_idx;
        m_rx_evt_type <= EVT_TX_PSN_ERR;
      end else begin
        m_rx_evt_idx  <= '0;
        m_rx_evt_type <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state       <= '0;
      rd_next_psn    <= '0;
      rd_unacked_psn <= '0;
      rd_rem_qpn     <= '0;
      rd_rem_addr    <= '0;
      rd_r_key       <= '0;
      rd_rem_ip_addr <= '0;
    end else begin
      rd_state       <= ent_q[rd_idx].state;
      rd_next_psn    <= ent_q[rd_idx].next_psn;
      rd_unacked_psn <= ent_q[rd_idx].unacked_psn;
      rd_rem_qpn     <= ent_q[rd_idx].rem_qpn;
      rd_rem_addr    <= ent_q[rd_idx].rem_addr;
      rd_r_key       <= ent_q[rd_idx].r_key;
      rd_rem_ip_addr <= ent_q[rd_idx].rem_ip_addr;
    end
  end

endmodule

// File: tb/tb_roce_qp_state_table.sv
// Directed self-checking bench for roce_qp_state_table.
module tb_roce_qp_state_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_disable;
  logic [1:0]  cfg_idx;
  logic [23:0] cfg_loc_qpn, cfg_rem_qpn, cfg_loc_psn;
  logic [63:0] cfg_rem_addr;
  logic [31:0] cfg_r_key, cfg_rem_ip_addr, cfg_dma_len;
  logic        s_tx_valid, s_tx_ready;
  logic [7:0]  s_tx_op_code;
  logic [23:0] s_tx_psn, s_tx_dest_qp;
  logic        s_tx_reth_valid;
  logic [63:0] s_tx_reth_v_addr;
  logic [31:0] s_tx_reth_length;
  logic        s_rx_valid, s_rx_ready;
  logic [7:0]  s_rx_op_code;
  logic [23:0] s_rx_psn, s_rx_dest_qp;
  logic [7:0]  s_rx_aeth_syndrome;
  logic [1:0]  rd_idx;
  logic [1:0]  rd_state;
  logic [23:0] rd_next_psn, rd_unacked_psn, rd_rem_qpn;
  logic [63:0] rd_rem_addr;
  logic [31:0] rd_r_key, rd_rem_ip_addr;
  logic [3:0]  stall;
  logic        m_tx_done_valid;
  logic [1:0]  m_tx_done_idx;
  logic        m_rx_evt_valid;
  logic [1:0]  m_rx_evt_idx;
  logic [1:0]  m_rx_evt_type;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  roce_qp_state_table #(
    .NUM_QP(4), .QP_IDX_W(2), .REM_ADDR_WIDTH(32), .MAX_OUTSTANDING(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_disable(cfg_disable), .cfg_idx(cfg_idx),
    .cfg_loc_qpn(cfg_loc_qpn), .cfg_rem_qpn(cfg_rem_qpn), .cfg_loc_psn(cfg_loc_psn),
    .cfg_rem_addr(cfg_rem_addr), .cfg_r_key(cfg_r_key),
    .cfg_rem_ip_addr(cfg_rem_ip_addr), .cfg_dma_len(cfg_dma_len),
    .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready), .s_tx_op_code(s_tx_op_code),
    .s_tx_psn(s_tx_psn), .s_tx_dest_qp(s_tx_dest_qp),
    .s_tx_reth_valid(s_tx_reth_valid), .s_tx_reth_v_addr(s_tx_reth_v_addr),
    .s_tx_reth_length(s_tx_reth_length),
    .s_rx_valid(s_rx_valid), .s_rx_ready(s_rx_ready), .s_rx_op_code(s_rx_op_code),
    .s_rx_psn(s_rx_psn), .s_rx_dest_qp(s_rx_dest_qp),
    .s_rx_aeth_syndrome(s_rx_aeth_syndrome),
    .rd_idx(rd_idx), .rd_state(rd_state), .rd_next_psn(rd_next_psn),
    .rd_unacked_psn(rd_unacked_psn), .rd_rem_qpn(rd_rem_qpn),
    .rd_rem_addr(rd_rem_addr), .rd_r_key(rd_r_key), .rd_rem_ip_addr(rd_rem_ip_addr),
    .stall(stall),
    .m_tx_done_valid(m_tx_done_valid), .m_tx_done_idx(m_tx_done_idx),
    .m_rx_evt_valid(m_rx_evt_valid), .m_rx_evt_idx(m_rx_evt_idx),
    .m_rx_evt_type(m_rx_evt_type)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cfg_valid       = 1'b0;
    s_tx_valid      = 1'b0;
    s_tx_reth_valid = 1'b0;
    s_rx_valid      = 1'b0;
  endtask

  task automatic cfg_qp(input logic [1:0] idx, input logic [23:0] loc, input logic [23:0] rem,
                        input logic [23:0] psn, input logic [63:0] addr, input logic [31:0] len);
    cfg_valid = 1'b1; cfg_disable = 1'b0; cfg_idx = idx;
    cfg_loc_qpn = loc; cfg_rem_qpn = rem; cfg_loc_psn = psn;
    cfg_rem_addr = addr; cfg_r_key = 32'hA5A5_0000 | 32'(idx); cfg_rem_ip_addr = 32'h0A00_0001;
    cfg_dma_len = len;
    #1;
    chk("cfg_blocks_tx", {63'd0, s_tx_ready}, 64'd0);
    step();
  endtask

  task automatic tx_set(input logic [7:0] op, input logic [23:0] psn, input logic [23:0] dest,
                        input logic reth, input logic [63:0] vaddr);
    s_tx_valid = 1'b1; s_tx_op_code = op; s_tx_psn = psn; s_tx_dest_qp = dest;
    s_tx_reth_valid = reth; s_tx_reth_v_addr = vaddr; s_tx_reth_length = 32'h100;
  endtask

  task automatic rx_set(input logic [23:0] psn, input logic [23:0] dest, input logic [7:0] syn);
    s_rx_valid = 1'b1; s_rx_op_code = 8'h11; s_rx_psn = psn; s_rx_dest_qp = dest;
    s_rx_aeth_syndrome = syn;
  endtask

  task automatic rd(input logic [1:0] idx);
    rd_idx = idx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 0; cfg_disable = 0; cfg_idx = 0; cfg_loc_qpn = 0; cfg_rem_qpn = 0;
    cfg_loc_psn = 0; cfg_rem_addr = 0; cfg_r_key = 0; cfg_rem_ip_addr = 0; cfg_dma_len = 0;
    s_tx_valid = 0; s_tx_op_code = 0; s_tx_psn = 0; s_tx_dest_qp = 0;
    s_tx_reth_valid = 0; s_tx_reth_v_addr = 0; s_tx_reth_length = 0;
    s_rx_valid = 0; s_rx_op_code = 0; s_rx_psn = 0; s_rx_dest_qp = 0; s_rx_aeth_syndrome = 0;
    rd_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'hF);
    chk("rst_tx_ready", {63'd0, s_tx_ready}, 64'd0);
    chk("rst_rd_state", 64'(rd_state), 64'd0);
    chk("rst_evt", {63'd0, m_rx_evt_valid}, 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("run_tx_ready", {63'd0, s_tx_ready}, 64'd1);

    // PSN window fill and ACK on idx1
    cfg_qp(2'd1, 24'h11, 24'h21, 24'h000100, 64'h0, 32'h100);
    chk("cfg1_stall", 64'(stall), 64'hD);
    for (int i = 0; i < 16; i++) begin
      tx_set(8'h04, 24'h000100 + 24'(i), 24'h21, 1'b0, 64'h0);
      step();
      if (i == 0)  chk("send_no_done", {63'd0, m_tx_done_valid}, 64'd0);
      if (i == 14) chk("stall1_15", {63'd0, stall[1]}, 64'd0);
      if (i == 15) chk("stall1_16", {63'd0, stall[1]}, 64'd1);
    end
    rd(2'd1);
    chk("q1_next", 64'(rd_next_psn), 64'h110);
    rx_set(24'h000105, 24'h11, 8'h00);
    step();
    chk("ack1_valid", {63'd0, m_rx_evt_valid}, 64'd1);
    chk("ack1_idx", 64'(m_rx_evt_idx), 64'd1);
    chk("ack1_type", 64'(m_rx_evt_type), 64'd0);
    chk("ack1_stall", {63'd0, stall[1]}, 64'd0);
    rx_set(24'h000120, 24'h11, 8'h00);
    step();
    chk("ack_oow_no_evt", {63'd0, m_rx_evt_valid}, 64'd0);
    rx_set(24'h000107, 24'h11, 8'h40);
    step();
    chk("syn10_no_evt", {63'd0, m_rx_evt_valid}, 64'd0);
    tx_set(8'h0A, 24'h000110, 24'h77, 1'b0, 64'h0);
    step();
    chk("miss_no_done", {63'd0, m_tx_done_valid}, 64'd0);
    chk("miss_no_evt", {63'd0, m_rx_evt_valid}, 64'd0);
    rd(2'd1);
    chk("q1_unacked", 64'(rd_unacked_psn), 64'h106);
    chk("q1_state", 64'(rd_state), 64'd1);
    chk("q1_next_after_miss", 64'(rd_next_psn), 64'h110);

    // PSN wrap on idx0
    cfg_qp(2'd0, 24'h10, 24'h20, 24'hFFFFFE, 64'h0, 32'h100);
    for (int i = 0; i < 4; i++) begin
      tx_set(8'h04, 24'hFFFFFE + 24'(i), 24'h20, 1'b0, 64'h0);
      step();
    end
    rx_set(24'h000001, 24'h10, 8'h00);
    step();
    chk("ack0_valid", {63'd0, m_rx_evt_valid}, 64'd1);
    chk("ack0_idx", 64'(m_rx_evt_idx), 64'd0);
    rd(2'd0);
    chk("q0_next_wrap", 64'(rd_next_psn), 64'h000002);
    chk("q0_unacked_wrap", 64'(rd_unacked_psn), 64'h000002);

    // Remote address advance on idx3
    cfg_qp(2'd3, 24'h13, 24'h23, 24'h000500, 64'h1_0000_FFFF_F000, 32'h2000);
    tx_set(8'h0A, 24'h000500, 24'h23, 1'b0, 64'h0);
    step();
    chk("done3_valid", {63'd0, m_tx_done_valid}, 64'd1);
    chk("done3_idx", 64'(m_tx_done_idx), 64'd3);
    step();
    chk("done3_pulse", {63'd0, m_tx_done_valid}, 64'd0);
    rd(2'd3);
    chk("q3_addr_wrap", rd_rem_addr, 64'h1_0000_0000_1000);
    tx_set(8'h06, 24'h000501, 24'h23, 1'b1, 64'h2_0000_0000_0040);
    step();
    chk("first_no_done", {63'd0, m_tx_done_valid}, 64'd0);
    tx_set(8'h08, 24'h000502, 24'h23, 1'b0, 64'h0);
    step();
    chk("last_done", {63'd0, m_tx_done_valid}, 64'd1);
    rd(2'd3);
    chk("q3_addr_reth_last", rd_rem_addr, 64'h2_0000_0000_2040);
    tx_set(8'h0A, 24'h000503, 24'h23, 1'b1, 64'h3_0000_FFFF_FFFF);
    step();
    rd(2'd3);
    chk("q3_addr_reth_only", rd_rem_addr, 64'h3_0000_0000_1FFF);
    tx_set(8'h04, 24'h000504, 24'h23, 1'b0, 64'h0);
    rx_set(24'h000503, 24'h13, 8'h00);
    step();
    chk("same_entry_ack", {63'd0, m_rx_evt_valid}, 64'd1);
    chk("same_entry_idx", 64'(m_rx_evt_idx), 64'd3);
    rd(2'd3);
    chk("q3_next_both", 64'(rd_next_psn), 64'h505);
    chk("q3_unacked_both", 64'(rd_unacked_psn), 64'h504);

    // NAK on idx2 and recovery
    cfg_qp(2'd2, 24'h12, 24'h22, 24'h000200, 64'h0, 32'h100);
    tx_set(8'h04, 24'h000200, 24'h22, 1'b0, 64'h0);
    step();
    rx_set(24'h000200, 24'h12, 8'h60);
    step();
    chk("nak_valid", {63'd0, m_rx_evt_valid}, 64'd1);
    chk("nak_idx", 64'(m_rx_evt_idx), 64'd2);
    chk("nak_type", 64'(m_rx_evt_type), 64'd1);
    chk("nak_stall", {63'd0, stall[2]}, 64'd1);
    rd(2'd2);
    chk("q2_err", 64'(rd_state), 64'd2);
    chk("q2_unacked_kept", 64'(rd_unacked_psn), 64'h200);
    tx_set(8'h0A, 24'h000201, 24'h22, 1'b0, 64'h0);
    step();
    chk("err_tx_no_done", {63'd0, m_tx_done_valid}, 64'd0);
    chk("err_tx_no_evt", {63'd0, m_rx_evt_valid}, 64'd0);
    rd(2'd2);
    chk("q2_next_dropped", 64'(rd_next_psn), 64'h201);
    cfg_qp(2'd2, 24'h12, 24'h22, 24'h000300, 64'h0, 32'h100);
    chk("recfg_stall", {63'd0, stall[2]}, 64'd0);
    rd(2'd2);
    chk("q2_recfg_state", 64'(rd_state), 64'd1);
    chk("q2_recfg_next", 64'(rd_next_psn), 64'h300);
    rx_set(24'h000300, 24'h12, 8'h20);
    step();
    chk("rnr_type", 64'(m_rx_evt_type), 64'd1);
    rd(2'd2);
    chk("q2_rnr_err", 64'(rd_state), 64'd2);

    // TX PSN error on idx1
    cfg_qp(2'd1, 24'h11, 24'h21, 24'h000103, 64'h0, 32'h100);
    tx_set(8'h04, 24'h000105, 24'h21, 1'b0, 64'h0);
    step();
    chk("psnerr_valid", {63'd0, m_rx_evt_valid}, 64'd1);
    chk("psnerr_idx", 64'(m_rx_evt_idx), 64'd1);
    chk("psnerr_type", 64'(m_rx_evt_type), 64'd2);
    rd(2'd1);
    chk("q1_psnerr_state", 64'(rd_state), 64'd2);
    chk("q1_psnerr_next", 64'(rd_next_psn), 64'h103);

    // Same-cycle TX_PSN_ERR (idx1) and NAK (idx0): NAK is reported
    cfg_qp(2'd1, 24'h11, 24'h21, 24'h000103, 64'h0, 32'h100);
    tx_set(8'h04, 24'h000999, 24'h21, 1'b0, 64'h0);
    rx_set(24'h000002, 24'h10, 8'h60);
    step();
    chk("prio_type", 64'(m_rx_evt_type), 64'd1);
    chk("prio_idx", 64'(m_rx_evt_idx), 64'd0);
    rd(2'd1);
    chk("prio_q1_err", 64'(rd_state), 64'd2);

    // Reset mid-traffic
    rd(2'd3);
    chk("pre_rst_q3", 64'(rd_state), 64'd1);
    tx_set(8'h04, 24'h000505, 24'h23, 1'b0, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'hF);
    chk("midrst_rd_state", 64'(rd_state), 64'd0);
    chk("midrst_rd_next", 64'(rd_next_psn), 64'd0);
    chk("midrst_ready", {63'd0, s_tx_ready}, 64'd0);
    s_tx_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
